// File: rtl/rfm_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the ring-oscillator frequency meter.
package rfm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_GATE,
        S_SETTLE,
        S_DONE
    } state_t;

    // WARM and SETTLE both cover the synchronizer depth plus two spare cycles.
    localparam int unsigned WARM_EXTRA   = 2;
    localparam int unsigned SETTLE_EXTRA = 2;

    function automatic int unsigned warm_cyc(input int unsigned sync_n);
        return sync_n + WARM_EXTRA;
    endfunction

    function automatic int unsigned settle_cyc(input int unsigned sync_n);
        return sync_n + SETTLE_EXTRA;
    endfunction

    function automatic int unsigned sel_width(input int unsigned num_ch, input int unsigned cnt_w);
        return $clog2(1 + num_ch * cnt_w / 8);
    endfunction

endpackage

// File: rtl/rfm_ring_counter.sv
`timescale 1ns/1ps
// Per-channel edge counter living in its ring-oscillator clock domain:
// synchronizes count_en/clear from clk, saturates at all-ones and flags overflow.
module rfm_ring_counter
    import rfm_pkg::*;
#(
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned SYNC_N = 2
) (
    input  logic             ring_clk,
    input  logic             rst,
    input  logic             count_en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] NEAR_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [SYNC_N-1:0] en_sync;
    logic [SYNC_N-1:0] clr_sync;
    logic              clr_async;

    always_ff @(posedge ring_clk or posedge rst) begin
        if (rst) begin
            en_sync  <= '0;
            clr_sync <= '0;
        end else begin
            en_sync[0]  <= count_en;
            clr_sync[0] <= clr;
            for (int unsigned i = 1; i < SYNC_N; i++) begin
                en_sync[i]  <= en_sync[i-1];
                clr_sync[i] <= clr_sync[i-1];
            end
        end
    end

    // clr_sync is a flop output, so OR-ing it into the async clear is glitch-free.
    assign clr_async = rst | clr_sync[SYNC_N-1];

    always_ff @(posedge ring_clk or posedge clr_async) begin
        if (clr_async) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en_sync[SYNC_N-1] && !ovf) begin
            cnt <= cnt + ONE;
            if (cnt == NEAR_MAX) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_freq_meter.sv
`timescale 1ns/1ps
// Multi-channel ring-oscillator frequency meter: counts ring edges over a
// programmable clk-cycle gate and reads results back byte-wise via sel.
module ring_freq_meter
    import rfm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned GATE_W = 8,
    parameter int unsigned SYNC_N = 2,
    parameter int unsigned SEL_W  = sel_width(NUM_CH, CNT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ring_clk,
    output logic [NUM_CH-1:0] ring_en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              debug,
    input  logic              trig,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [SEL_W-1:0]  sel,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned BYTES  = CNT_W / 8;
    localparam int unsigned NBYTES = NUM_CH * BYTES;
    localparam int unsigned TMR_W  = (GATE_W > 8) ? GATE_W : 8;
    localparam logic [TMR_W-1:0] WARM_LOAD   = TMR_W'(warm_cyc(SYNC_N) - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(settle_cyc(SYNC_N) - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    state_t              state, state_nx;
    logic [TMR_W-1:0]    tmr, tmr_nx;
    logic                trig_q;
    logic                trig_rise;
    logic                start;
    logic                capture;
    logic                busy_nx;
    logic [NUM_CH-1:0]   en_lat;
    logic [GATE_W-1:0]   gate_lat;
    logic [NUM_CH-1:0]   count_en;
    logic                clr;

    logic [NUM_CH*CNT_W-1:0] cnt_flat;
    logic [NUM_CH-1:0]       ovf_live;
    logic [NUM_CH*CNT_W-1:0] res_flat;
    logic [NUM_CH-1:0]       ovf_res;
    logic [5:0]              ovf_field;
    logic [7:0]              status;
    logic [7:0]              rd_nx;

    assign trig_rise = trig & ~trig_q;

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        start    = 1'b0;
        capture  = 1'b0;
        if (tmr != '0) begin
            tmr_nx = tmr - TMR_ONE;
        end
        case (state)
            S_IDLE, S_DONE: begin
                if (trig_rise) begin
                    state_nx = S_WARM;
                    tmr_nx   = WARM_LOAD;
                    start    = 1'b1;
                end
            end
            S_WARM: begin
                if (tmr == '0) begin
                    state_nx = S_GATE;
                    tmr_nx   = TMR_W'(gate_lat);
                end
            end
            S_GATE: begin
                if (tmr == '0) begin
                    state_nx = S_SETTLE;
                    tmr_nx   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (tmr == '0) begin
                    state_nx = S_DONE;
                    capture  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx == S_WARM) || (state_nx == S_GATE) || (state_nx == S_SETTLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tmr      <= '0;
            trig_q   <= 1'b0;
            en_lat   <= '0;
            gate_lat <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ring_en  <= '0;
            count_en <= '0;
            clr      <= 1'b0;
        end else begin
            state    <= state_nx;
            tmr      <= tmr_nx;
            trig_q   <= trig;
            busy     <= busy_nx;
            done     <= (state_nx == S_DONE);
            clr      <= (state_nx == S_WARM);
            count_en <= (state_nx == S_GATE) ? en_lat : '0;
            if (start) begin
                en_lat   <= ch_en;
                gate_lat <= gate_len;
            end
            // Outputs are decoded from next state so they line up with state itself.
            if (debug) begin
                ring_en <= ch_en;
            end else if (busy_nx) begin
                ring_en <= start ? ch_en : en_lat;
            end else begin
                ring_en <= '0;
            end
        end
    end

    // A disabled channel's oscillator never runs the clear through; capture masks it to 0.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rfm_ring_counter #(
            .CNT_W (CNT_W),
            .SYNC_N(SYNC_N)
        ) u_cnt (
            .ring_clk(ring_clk[g]),
            .rst     (rst),
            .count_en(count_en[g]),
            .clr     (clr),
            .cnt     (cnt_flat[g*CNT_W +: CNT_W]),
            .ovf     (ovf_live[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_flat <= '0;
            ovf_res  <= '0;
        end else if (start) begin
            res_flat <= '0;
            ovf_res  <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                res_flat[i*CNT_W +: CNT_W] <= en_lat[i] ? cnt_flat[i*CNT_W +: CNT_W] : '0;
                ovf_res[i]                 <= en_lat[i] & ovf_live[i];
            end
        end
    end

    if (NUM_CH <= 6) begin : g_ovf_bits
        assign ovf_field = 6'(ovf_res);
    end else begin : g_ovf_any
        assign ovf_field = {|ovf_res, 5'b0};
    end

    assign status = {done, busy, ovf_field};

    always_comb begin
        rd_nx = '0;
        if (sel == '0) begin
            rd_nx = status;
        end else begin
            for (int unsigned j = 0; j < NBYTES; j++) begin
                if (sel == SEL_W'(j + 1)) begin
                    rd_nx = res_flat[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_nx;
        end
    end

endmodule
